iob_native_mem_resp: RTL and testbench

IOB_NATIVE_MEM_RESP -- requirements
Module: iob_native_mem_resp

---
 rtl/iob_native_mem_resp.sv | 112 +++++++++++
 tb/tb_iob_native_mem_resp.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_native_mem_resp.sv
// Native-bus memory responder: word memory with byte-lane writes,
// a fixed busy window after each request, and a one-cycle read strobe.
module iob_native_mem_resp #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                avalid_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                ready_o,
  output logic                rvalid_o
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);
  localparam int NB    = DATA_W / 8;
  localparam bit HAS_WAIT = (WAIT_CYCLES != 0);
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]        state_q;
  logic [3:0]        cnt_q;
  logic              up_q;
  logic              rd_pend_q;
  logic [DATA_W-1:0] pend_q;

  logic              accept;
  logic              is_wr;
  logic              busy_end;
  logic [ADDR_W-3:0] widx;
  logic              unused_lsb;

  assign ready_o    = up_q & (state_q == S_IDLE);
  assign accept     = avalid_i & ready_o;
  assign is_wr      = |wstrb_i;
  assign widx       = addr_i[ADDR_W-1:2];
  assign busy_end   = (state_q == S_BUSY) & (cnt_q == 4'd0);
  assign unused_lsb = ^addr_i[1:0];

  // Byte-lane write at the acceptance edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && is_wr) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb_i[b]) begin
          mem[widx][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  // Busy-window FSM; up_q keeps ready low until the first edge out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      up_q    <= 1'b0;
    end else begin
      up_q <= 1'b1;
      unique case (1'b1)
        (state_q == S_IDLE): begin
          if (accept && HAS_WAIT) begin
            state_q <= S_BUSY;
            cnt_q   <= CNT_LOAD;
          end
        end
        (state_q == S_BUSY): begin
          if (cnt_q == 4'd0) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Read data is snapshotted at acceptance and released as the window ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_o  <= 1'b0;
      rdata_o   <= '0;
      rd_pend_q <= 1'b0;
      pend_q    <= '0;
    end else begin
      rvalid_o <= 1'b0;
      if (accept && !is_wr) begin
        if (HAS_WAIT) begin
          rd_pend_q <= 1'b1;
          pend_q    <= mem[widx];
        end else begin
          rvalid_o <= 1'b1;
          rdata_o  <= mem[widx];
        end
      end
      if (busy_end && rd_pend_q) begin
        rvalid_o  <= 1'b1;
        rdata_o   <= pend_q;
        rd_pend_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iob_native_mem_resp.sv
// Bench for iob_native_mem_resp: three instances (wait 0, 1, 3),
// directed scenarios plus random traffic against a cycle-count model.
module tb_iob_native_mem_resp;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n  [N];
  logic        avalid [N];
  logic [9:0]  addr   [N];
  logic [31:0] wdata  [N];
  logic [3:0]  wstrb  [N];
  logic [31:0] rdata  [N];
  logic        ready  [N];
  logic        rvalid [N];

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mm [N][256];
  logic [31:0] mk [N][256];

  for (genvar g = 0; g < N; g++) begin : g_dut
    iob_native_mem_resp #(
      .DATA_W(32),
      .ADDR_W(10),
      .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 1 : 3))
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n[g]),
      .avalid_i(avalid[g]),
      .addr_i  (addr[g]),
      .wdata_i (wdata[g]),
      .wstrb_i (wstrb[g]),
      .rdata_o (rdata[g]),
      .ready_o (ready[g]),
      .rvalid_o(rvalid[g])
    );
  end

  function automatic int wc(int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(int k, logic [9:0] a,
                     logic [31:0] d, logic [3:0] s);
    addr[k] = a;
    wdata[k] = d;
    wstrb[k] = s;
    avalid[k] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (ready[k]) begin
        cyc();
        avalid[k] = 1'b0;
        return;
      end
      cyc();
    end
    $display("FAIL acc_timeout k=%0d never ready", k);
    $fatal(1, "request never accepted");
  endtask

  task automatic test_reset();
    for (int k = 0; k < N; k++) begin
      rst_n[k] = 1'b0;
      avalid[k] = 1'b0;
      addr[k] = '0;
      wdata[k] = '0;
      wstrb[k] = '0;
    end
    #13;
    for (int k = 0; k < N; k++) begin
      n_chk++;
      if (ready[k] !== 1'b0 || rvalid[k] !== 1'b0
          || rdata[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL rst_vals k=%0d got rdy=%b rv=%b rd=%h exp 0 0 0",
                 k, ready[k], rvalid[k], rdata[k]);
      end
    end
    @(negedge clk);
    for (int k = 0; k < N; k++) rst_n[k] = 1'b1;
    #1;
    for (int k = 0; k < N; k++) begin
      n_chk++;
      if (ready[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_rdy_pre k=%0d got %b exp 0", k, ready[k]);
      end
    end
    cyc();
    for (int k = 0; k < N; k++) begin
      n_chk++;
      if (ready[k] !== 1'b1 || rvalid[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_rdy_post k=%0d got rdy=%b rv=%b exp 1 0",
                 k, ready[k], rvalid[k]);
      end
    end
  endtask

  task automatic test_basic();
    addr[1] = 10'h010;
    wdata[1] = 32'hDEADBEEF;
    wstrb[1] = 4'hF;
    avalid[1] = 1'b1;
    n_chk++;
    if (ready[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_rdy_T got %b exp 1", ready[1]);
    end
    cyc();
    avalid[1] = 1'b0;
    n_chk++;
    if (ready[1] !== 1'b0 || rvalid[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_wr_busy got rdy=%b rv=%b exp 0 0",
               ready[1], rvalid[1]);
    end
    cyc();
    n_chk++;
    if (ready[1] !== 1'b1 || rvalid[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_wr_done got rdy=%b rv=%b exp 1 0",
               ready[1], rvalid[1]);
    end
    wstrb[1] = 4'h0;
    wdata[1] = 32'h0;
    avalid[1] = 1'b1;
    cyc();
    avalid[1] = 1'b0;
    n_chk++;
    if (ready[1] !== 1'b0 || rvalid[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_rd_busy got rdy=%b rv=%b exp 0 0",
               ready[1], rvalid[1]);
    end
    cyc();
    n_chk++;
    if (ready[1] !== 1'b1 || rvalid[1] !== 1'b1
        || rdata[1] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL basic_rd_resp got rdy=%b rv=%b rd=%h exp 1 1 deadbeef",
               ready[1], rvalid[1], rdata[1]);
    end
    cyc();
    n_chk++;
    if (rvalid[1] !== 1'b0 || rdata[1] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL basic_hold got rv=%b rd=%h exp 0 deadbeef",
               rvalid[1], rdata[1]);
    end
  endtask

  task automatic test_lanes();
    acc(1, 10'h020, 32'h11223344, 4'hF);
    acc(1, 10'h020, 32'hAABBCCDD, 4'h5);
    acc(1, 10'h020, 32'h0, 4'h0);
    cyc();
    n_chk++;
    if (rvalid[1] !== 1'b1 || rdata[1] !== 32'h11BB33DD) begin
      n_fail++;
      $display("FAIL lanes got rv=%b rd=%h exp 1 11bb33dd",
               rvalid[1], rdata[1]);
    end
  endtask

  task automatic test_back_to_back();
    acc(0, 10'h000, 32'd1, 4'hF);
    acc(0, 10'h004, 32'd2, 4'hF);
    acc(0, 10'h008, 32'd3, 4'hF);
    for (int i = 0; i < 3; i++) begin
      addr[0] = 10'(4 * i);
      wstrb[0] = 4'h0;
      avalid[0] = 1'b1;
      cyc();
      n_chk++;
      if (ready[0] !== 1'b1 || rvalid[0] !== 1'b1
          || rdata[0] !== 32'(i + 1)) begin
        n_fail++;
        $display("FAIL b2b_%0d got rdy=%b rv=%b rd=%h exp 1 1 %h",
                 i, ready[0], rvalid[0], rdata[0], 32'(i + 1));
      end
    end
    avalid[0] = 1'b0;
    cyc();
    n_chk++;
    if (rvalid[0] !== 1'b0 || rdata[0] !== 32'd3) begin
      n_fail++;
      $display("FAIL b2b_end got rv=%b rd=%h exp 0 3",
               rvalid[0], rdata[0]);
    end
  endtask

  task automatic test_hold();
    acc(2, 10'h040, 32'h0BADF00D, 4'hF);
    repeat (3) cyc();
    addr[2] = 10'h040;
    wstrb[2] = 4'h0;
    avalid[2] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      n_chk++;
      if (ready[2] !== (i % 4 == 0)
          || rvalid[2] !== (i % 4 == 0 && i > 0)) begin
        n_fail++;
        $display("FAIL hold_%0d got rdy=%b rv=%b exp %b %b", i,
                 ready[2], rvalid[2], i % 4 == 0, i % 4 == 0 && i > 0);
      end
      if (rvalid[2]) begin
        n_chk++;
        if (rdata[2] !== 32'h0BADF00D) begin
          n_fail++;
          $display("FAIL hold_data_%0d got %h exp 0badf00d",
                   i, rdata[2]);
        end
      end
      cyc();
    end
    avalid[2] = 1'b0;
    repeat (5) cyc();
  endtask

  task automatic test_reset_busy();
    acc(2, 10'h080, 32'hA5A55A5A, 4'hF);
    repeat (3) cyc();
    acc(2, 10'h080, 32'h0, 4'h0);
    #1 rst_n[2] = 1'b0;
    #2;
    n_chk++;
    if (ready[2] !== 1'b0 || rvalid[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL rstb_in got rdy=%b rv=%b exp 0 0",
               ready[2], rvalid[2]);
    end
    @(negedge clk);
    rst_n[2] = 1'b1;
    #1;
    n_chk++;
    if (ready[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL rstb_rel got rdy=%b exp 0", ready[2]);
    end
    cyc();
    n_chk++;
    if (ready[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL rstb_up got rdy=%b exp 1", ready[2]);
    end
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (rvalid[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL rstb_norv_%0d got rv=%b exp 0", i, rvalid[2]);
      end
      cyc();
    end
    acc(2, 10'h080, 32'h0, 4'h0);
    repeat (3) cyc();
    n_chk++;
    if (rvalid[2] !== 1'b1 || rdata[2] !== 32'hA5A55A5A) begin
      n_fail++;
      $display("FAIL rstb_keep got rv=%b rd=%h exp 1 a5a55a5a",
               rvalid[2], rdata[2]);
    end
  endtask

  task automatic test_top_word();
    acc(1, 10'h3FC, 32'hCAFEF00D, 4'hF);
    acc(1, 10'h000, 32'h12345678, 4'hF);
    acc(1, 10'h3FC, 32'h0, 4'h0);
    cyc();
    n_chk++;
    if (rvalid[1] !== 1'b1 || rdata[1] !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL top_rd got rv=%b rd=%h exp 1 cafef00d",
               rvalid[1], rdata[1]);
    end
    acc(1, 10'h000, 32'h0, 4'h0);
    cyc();
    n_chk++;
    if (rvalid[1] !== 1'b1 || rdata[1] !== 32'h12345678) begin
      n_fail++;
      $display("FAIL top_alias got rv=%b rd=%h exp 1 12345678",
               rvalid[1], rdata[1]);
    end
  endtask

  task automatic test_random(int k);
    int w;
    int c;
    int busy_until;
    int resp_cyc;
    bit have;
    bit acc_now;
    logic [9:0]  ra;
    logic [31:0] rd;
    logic [3:0]  rs;
    logic [31:0] resp_d, resp_m, exp_d, exp_m;
    w = wc(k);
    avalid[k] = 1'b0;
    repeat (5) cyc();
    for (int i = 0; i < 256; i++) mk[k][i] = '0;
    c = 0;
    busy_until = -1;
    resp_cyc = -1;
    have = 1'b0;
    exp_m = '0;
    exp_d = '0;
    resp_d = '0;
    resp_m = '0;
    ra = '0;
    rd = '0;
    rs = '0;
    for (int i = 0; i < 300; i++) begin
      if (!have && $urandom_range(0, 2) != 0) begin
        int wd;
        have = 1'b1;
        wd = $urandom_range(0, 7);
        if (wd == 7) wd = 255;
        ra = 10'((wd << 2) | $urandom_range(0, 3));
        rd = $urandom;
        rs = ($urandom_range(0, 1) != 0) ? 4'h0
             : 4'($urandom_range(1, 15));
      end
      avalid[k] = have;
      addr[k] = ra;
      wdata[k] = rd;
      wstrb[k] = rs;
      if (c == resp_cyc) begin
        exp_d = resp_d;
        exp_m = resp_m;
      end
      n_chk++;
      if (ready[k] !== (c > busy_until)
          || rvalid[k] !== (c == resp_cyc)) begin
        n_fail++;
        $display("FAIL rnd%0d_c%0d got rdy=%b rv=%b exp %b %b", k, c,
                 ready[k], rvalid[k], c > busy_until, c == resp_cyc);
      end
      n_chk++;
      if (((rdata[k] ^ exp_d) & exp_m) !== 32'h0) begin
        n_fail++;
        $display("FAIL rnd%0d_data_c%0d got %h exp %h mask %h",
                 k, c, rdata[k], exp_d, exp_m);
      end
      acc_now = have && (c > busy_until);
      if (acc_now) begin
        if (rs != 4'h0) begin
          for (int b = 0; b < 4; b++) begin
            if (rs[b]) begin
              mm[k][ra[9:2]][b*8 +: 8] = rd[b*8 +: 8];
              mk[k][ra[9:2]][b*8 +: 8] = 8'hFF;
            end
          end
        end else begin
          resp_cyc = c + 1 + w;
          resp_d = mm[k][ra[9:2]];
          resp_m = mk[k][ra[9:2]];
        end
        busy_until = c + w;
        have = 1'b0;
      end
      cyc();
      c++;
    end
    avalid[k] = 1'b0;
    repeat (5) cyc();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lanes();
    test_back_to_back();
    test_hold();
    test_reset_busy();
    test_top_word();
    for (int k = 0; k < N; k++) test_random(k);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
